// File: rtl/vga_bounce_box.sv
// Moving-box pixel source: draws a bouncing rectangle over a gradient background.
// Optional macro VGA_BOUNCE_COLOR_CYCLE_EN rotates the box colour on every bounce.
module vga_bounce_box #(
  parameter int          H_VISIBLE = 640,
  parameter int          V_VISIBLE = 480,
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          SPEED     = 2,
  parameter logic [11:0] BOX_COLOR = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        enable,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] X_MAX = 11'(H_VISIBLE - BOX_W);
  localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - BOX_H);
  localparam logic [10:0] STEP  = 11'(SPEED);

  // POS = RIGHT on the X axis, DOWN on the Y axis.
  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  // Motion state collected in one struct so checkers can bind a single signal.
  typedef struct packed {
    dir_t       x_dir;
    dir_t       y_dir;
    logic [9:0] box_x;
    logic [9:0] box_y;
  } motion_t;

  motion_t    st, st_nxt;
  logic       frame_tick;
  logic       flip;
  logic [10:0] x_sum, y_sum;
  logic [11:0] colour;

  assign frame_tick = (h_cnt == 10'd0) && (v_cnt == 10'(V_VISIBLE));
  assign x_sum = {1'b0, st.box_x} + STEP;
  assign y_sum = {1'b0, st.box_y} + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '{x_dir: DIR_POS, y_dir: DIR_POS, box_x: 10'd0, box_y: 10'd0};
      frame_cnt <= 8'd0;
    end else begin
      st <= st_nxt;
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    st_nxt = st;
    if (frame_tick && enable) begin
      case (st.x_dir)
        DIR_POS: begin
          if (x_sum >= X_MAX) begin
            st_nxt.box_x = X_MAX[9:0];
            st_nxt.x_dir = DIR_NEG;
          end else begin
            st_nxt.box_x = x_sum[9:0];
          end
        end
        default: begin
          if ({1'b0, st.box_x} <= STEP) begin
            st_nxt.box_x = 10'd0;
            st_nxt.x_dir = DIR_POS;
          end else begin
            st_nxt.box_x = st.box_x - STEP[9:0];
          end
        end
      endcase
      case (st.y_dir)
        DIR_POS: begin
          if (y_sum >= Y_MAX) begin
            st_nxt.box_y = Y_MAX[9:0];
            st_nxt.y_dir = DIR_NEG;
          end else begin
            st_nxt.box_y = y_sum[9:0];
          end
        end
        default: begin
          if ({1'b0, st.box_y} <= STEP) begin
            st_nxt.box_y = 10'd0;
            st_nxt.y_dir = DIR_POS;
          end else begin
            st_nxt.box_y = st.box_y - STEP[9:0];
          end
        end
      endcase
    end
  end

  // A corner hit flips both axes but still counts as one bounce.
  assign flip = (st_nxt.x_dir != st.x_dir) || (st_nxt.y_dir != st.y_dir);

`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    colour <= BOX_COLOR;
    else if (flip) colour <= {colour[7:0], colour[11:8]};
  end
`else
  assign colour = BOX_COLOR;
  logic unused_flip;
  assign unused_flip = flip;
`endif

  assign box_x = st.box_x;
  assign box_y = st.box_y;

  logic        active, in_box;
  logic [11:0] rgb_nxt;

  assign active = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
  assign in_box = (h_cnt >= st.box_x) && ({1'b0, h_cnt} < {1'b0, st.box_x} + 11'(BOX_W)) &&
                  (v_cnt >= st.box_y) && ({1'b0, v_cnt} < {1'b0, st.box_y} + 11'(BOX_H));

  always_comb begin
    rgb_nxt = 12'h000;
    if (active) rgb_nxt = in_box ? colour : {h_cnt[9:6], v_cnt[8:5], 4'h0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb_out   <= rgb_nxt;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: reference model of box motion plus a pixel scoreboard.
module tb_vga_bounce_box;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out;
  logic [9:0]  box_x, box_y;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  logic [13:0] exp_q[$];

  // Reference model state
  int          m_x, m_y, m_fc;
  bit          m_right, m_down;
  logic [11:0] m_color;

  vga_bounce_box dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .enable(enable),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .box_x(box_x), .box_y(box_y), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_fc = 0; m_right = 1; m_down = 1; m_color = 12'hFF0;
  endtask

  function automatic logic [11:0] exp_pix(input int h, input int v);
    logic [9:0] hv, vv;
    hv = 10'(h); vv = 10'(v);
    if (h >= 640 || v >= 480) return 12'h000;
    if (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) return m_color;
    return {hv[9:6], vv[8:5], 4'h0};
  endfunction

  task automatic pixel(input int h, input int v, input logic hs, input logic vs);
    @(negedge clk);
    h_cnt = 10'(h); v_cnt = 10'(v); hsync_in = hs; vsync_in = vs;
    exp_q.push_back({hs, vs, exp_pix(h, v)});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check("pixel_queue_empty", 32'd1, 32'd0);
    end else begin
      check($sformatf("pixel_h%0d_v%0d", h, v), {18'd0, hsync_out, vsync_out, rgb_out},
            {18'd0, exp_q.pop_front()});
    end
  endtask

  // One frame tick, then one ordinary blanking cycle; model updated alongside.
  task automatic tick(input int n);
    bit flip;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_cnt = 10'd0; v_cnt = 10'd480;
      flip = 0;
      if (enable) begin
        if (m_right) begin
          if (m_x + 2 >= 608) begin m_x = 608; m_right = 0; flip = 1; end
          else m_x = m_x + 2;
        end else begin
          if (m_x <= 2) begin m_x = 0; m_right = 1; flip = 1; end
          else m_x = m_x - 2;
        end
        if (m_down) begin
          if (m_y + 2 >= 448) begin m_y = 448; m_down = 0; flip = 1; end
          else m_y = m_y + 2;
        end else begin
          if (m_y <= 2) begin m_y = 0; m_down = 1; flip = 1; end
          else m_y = m_y - 2;
        end
      end
`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
      if (flip) m_color = {m_color[7:0], m_color[11:8]};
`endif
      m_fc = (m_fc + 1) % 256;
      @(negedge clk);
      v_cnt = 10'd481;
      check("tick_box_x", 32'(box_x), 32'(m_x));
      check("tick_box_y", 32'(box_y), 32'(m_y));
      check("tick_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    end
  endtask

  initial begin
    int fc_start;
    model_reset();
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", 32'(rgb_out), 32'h000);
    check("rst_hsync", 32'(hsync_out), 32'd1);
    check("rst_vsync", 32'(vsync_out), 32'd1);
    check("rst_box_x", 32'(box_x), 32'd0);
    check("rst_box_y", 32'(box_y), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First pixel after reset lands inside the box at (0,0)
    pixel(0, 0, 1'b0, 1'b1);
    check("first_pixel_const", 32'(rgb_out), 32'hFF0);
    pixel(100, 200, 1'b1, 1'b0);

    // Move to (10,10) and probe the box edges
    enable = 1'b1;
    tick(5);
    check("box_at_10_x", 32'(box_x), 32'd10);
    pixel(10, 10, 1'b1, 1'b1);
    pixel(9, 10, 1'b1, 1'b1);
    pixel(41, 41, 1'b0, 1'b1);
    pixel(42, 10, 1'b1, 1'b1);
    pixel(10, 42, 1'b1, 1'b1);
    pixel(10, 9, 1'b1, 1'b1);
    pixel(640, 10, 1'b1, 1'b1);
    pixel(300, 479, 1'b1, 1'b1);
    pixel(639, 480 + 5, 1'b1, 1'b0);

    // Frozen box while frame_cnt keeps counting
    enable = 1'b0;
    tick(5);
    check("frozen_box_x", 32'(box_x), 32'd10);
    check("frozen_frame_cnt", 32'(frame_cnt), 32'd10);

    // Y reaches the bottom limit after 224 enabled ticks
    enable = 1'b1;
    tick(219);
    check("y_bottom", 32'(box_y), 32'd448);
    pixel(m_x, m_y, 1'b1, 1'b1);
    pixel(m_x + 31, m_y + 31, 1'b1, 1'b1);
    tick(1);
    check("y_reflect", 32'(box_y), 32'd446);
    // X reaches the right limit after 304 enabled ticks, then turns back
    tick(79);
    check("x_right", 32'(box_x), 32'd608);
    pixel(m_x + 31, m_y, 1'b1, 1'b1);
    pixel(639, m_y, 1'b1, 1'b1);
    tick(1);
    check("x_reflect", 32'(box_x), 32'd606);
    pixel(m_x, m_y, 1'b1, 1'b1);

    // frame_cnt wraps back to its start after 256 ticks
    enable = 1'b0;
    fc_start = m_fc;
    tick(256);
    check("frame_wrap", 32'(frame_cnt), 32'(fc_start));

    // Reset, travel to (100,100), then reset mid-line
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(50);
    check("box_100_x", 32'(box_x), 32'd100);
    check("box_100_y", 32'(box_y), 32'd100);
    pixel(100, 100, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_box_x", 32'(box_x), 32'd0);
    check("midrst_box_y", 32'(box_y), 32'd0);
    check("midrst_rgb", 32'(rgb_out), 32'h000);
    check("midrst_hsync", 32'(hsync_out), 32'd1);
    check("midrst_vsync", 32'(vsync_out), 32'd1);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_step", 32'(box_x), 32'd2);
    pixel(5, 5, 1'b1, 1'b1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
